// File: rtl/meteor_spawn_rng.sv
`default_nettype none
// ============================================================================
//  Module   : meteor_spawn_rng
//  Purpose  : Pseudo-random meteor spawn generator. A free-running 32-bit
//             LFSR (reseedable from a CPU-written seed) is sampled once every
//             SPAWN_PERIOD enabled frame ticks and turned into a spawn
//             descriptor (x position, fall speed, size class). The descriptor
//             is offered on a valid/ready handshake. Spawn ticks that arrive
//             while a descriptor is still being generated or offered are
//             counted in a saturating drop counter.
//
//  Ports    : clk          - single clock
//             reset        - synchronous, active-high reset
//             seed[31:0]   - seed value; any change reloads the LFSR
//             enable       - spawning enabled while high; low flushes
//             frame_tick   - one-cycle pulse per video frame
//             spawn_ready  - consumer accepts the offered descriptor
//             spawn_valid  - a spawn descriptor is offered
//             spawn_x      - horizontal position, 0..X_MAX-1
//             spawn_speed  - fall speed, 1..7
//             spawn_size   - size class, 0..3
//             drop_count   - saturating count of dropped spawn ticks
//
//  Revision : 1.0 - initial release
// ============================================================================
module meteor_spawn_rng #(
    parameter int SPAWN_PERIOD = 30,   // frame ticks between spawn attempts, 1..255
    parameter int X_MAX        = 640   // exclusive upper bound of spawn_x, 512..1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [9:0]  spawn_x,
    output logic [2:0]  spawn_speed,
    output logic [1:0]  spawn_size,
    output logic [7:0]  drop_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0]  c_LAST_FRAME = 8'(SPAWN_PERIOD - 1);
    localparam logic [9:0]  c_X_MAX      = 10'(X_MAX);
    localparam logic [31:0] c_LFSR_INIT  = 32'h0000_0001;

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_GEN     = 2'd1;
    localparam logic [1:0]  c_ST_OFFER   = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] r_lfsr;
    logic [31:0] r_seed_q;
    logic [7:0]  r_frame_cnt;
    logic [1:0]  r_state;
    logic        r_valid;
    logic [9:0]  r_x;
    logic [2:0]  r_speed;
    logic [1:0]  r_size;
    logic [7:0]  r_drop_cnt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_lfsr_fb;
    logic        w_seed_load;
    logic [31:0] w_seed_value;
    logic        w_spawn_tick;
    logic        w_drop;
    logic [9:0]  w_raw_x;
    logic [9:0]  w_x;
    logic [2:0]  w_speed;

    assign w_lfsr_fb    = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];

    // The seed register is edge-detected against its last loaded value, so a
    // CPU rewriting the same seed does not disturb the running sequence.
    // An all-zero seed would lock the LFSR, so it is mapped to 1.
    assign w_seed_load  = (seed != r_seed_q);
    assign w_seed_value = (seed == 32'd0) ? c_LFSR_INIT : seed;

    // The spawn tick is the frame tick on which the counter wraps.
    assign w_spawn_tick = enable && frame_tick && (r_frame_cnt == c_LAST_FRAME);

    // Any spawn tick that cannot start a generation is lost. This includes a
    // tick landing in the same cycle as the OFFER handshake.
    assign w_drop       = w_spawn_tick && (r_state != c_ST_IDLE);

    // Single conditional subtraction folds 0..1023 into 0..X_MAX-1; with
    // X_MAX >= 512 one subtraction is always enough.
    assign w_raw_x      = r_lfsr[9:0];
    assign w_x          = (w_raw_x < c_X_MAX) ? w_raw_x : (w_raw_x - c_X_MAX);

    // A speed of 0 would leave the meteor stuck at the top of the screen.
    assign w_speed      = (r_lfsr[12:10] == 3'd0) ? 3'd1 : r_lfsr[12:10];

    // ------------------------------------------------------------------------
    // LFSR and seed tracking (independent of enable)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr   <= c_LFSR_INIT;
            r_seed_q <= 32'd0;
        end else if (w_seed_load) begin
            r_lfsr   <= w_seed_value;
            r_seed_q <= seed;
        end else begin
            r_lfsr   <= {r_lfsr[30:0], w_lfsr_fb};
        end
    end

    // ------------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= 8'd0;
        end else if (!enable) begin
            r_frame_cnt <= 8'd0;
        end else if (frame_tick) begin
            if (r_frame_cnt == c_LAST_FRAME) begin
                r_frame_cnt <= 8'd0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Spawn FSM with registered descriptor outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_valid <= 1'b0;
            r_x     <= 10'd0;
            r_speed <= 3'd0;
            r_size  <= 2'd0;
        end else if (!enable) begin
            // Flush: the pending offer is withdrawn without a handshake.
            r_state <= c_ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_spawn_tick) begin
                        r_state <= c_ST_GEN;
                    end
                end
                c_ST_GEN: begin
                    // Sample the LFSR value present in this cycle, before the
                    // edge advances or reloads it.
                    r_x     <= w_x;
                    r_speed <= w_speed;
                    r_size  <= r_lfsr[14:13];
                    r_valid <= 1'b1;
                    r_state <= c_ST_OFFER;
                end
                c_ST_OFFER: begin
                    // r_valid is always high here, so ready alone completes
                    // the handshake; descriptor registers simply hold.
                    if (spawn_ready) begin
                        r_valid <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating drop counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign spawn_valid = r_valid;
    assign spawn_x     = r_x;
    assign spawn_speed = r_speed;
    assign spawn_size  = r_size;
    assign drop_count  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_meteor_spawn_rng.sv
`default_nettype none
// ============================================================================
//  Module   : tb_meteor_spawn_rng
//  Purpose  : Self-checking bench for meteor_spawn_rng. A behavioural model
//             tracks the expected descriptor, handshake and drop behaviour and
//             is compared against the DUT every cycle; directed sections pin
//             hand-computed values, followed by a randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_meteor_spawn_rng;

    localparam int c_PERIOD = 2;
    localparam int c_XMAX   = 640;

    localparam int P_IDLE  = 0;
    localparam int P_GEN   = 1;
    localparam int P_OFFER = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] seed;
    logic        enable;
    logic        frame_tick;
    logic        spawn_ready;
    logic        spawn_valid;
    logic [9:0]  spawn_x;
    logic [2:0]  spawn_speed;
    logic [1:0]  spawn_size;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    meteor_spawn_rng #(
        .SPAWN_PERIOD (c_PERIOD),
        .X_MAX        (c_XMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seed        (seed),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_x     (spawn_x),
        .spawn_speed (spawn_speed),
        .spawn_size  (spawn_size),
        .drop_count  (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: a phase (idle / generating / offering), a pending
    // descriptor and integer counters, advanced once per rising edge.
    // ------------------------------------------------------------------------
    logic [31:0] m_lfsr;
    logic [31:0] m_seed_q;
    int          m_frame;
    int          m_phase;
    bit          m_valid;
    int          m_x, m_speed, m_size, m_drop;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        logic [31:0] l_cur;
        bit          l_tick;
        int          l_raw;
        if (reset) begin
            m_lfsr   = 32'h1;
            m_seed_q = 32'h0;
            m_frame  = 0;
            m_phase  = P_IDLE;
            m_valid  = 1'b0;
            m_x      = 0;
            m_speed  = 0;
            m_size   = 0;
            m_drop   = 0;
            m_live   = 1'b1;
        end else if (m_live) begin
            l_cur  = m_lfsr;
            l_tick = enable && frame_tick && (m_frame == c_PERIOD - 1);

            if (seed != m_seed_q) begin
                m_lfsr   = (seed == 32'h0) ? 32'h1 : seed;
                m_seed_q = seed;
            end else begin
                m_lfsr = lfsr_step(m_lfsr);
            end

            if (!enable)         m_frame = 0;
            else if (frame_tick) m_frame = (m_frame + 1) % c_PERIOD;

            if (l_tick && m_phase != P_IDLE && m_drop < 255) m_drop++;

            if (!enable) begin
                m_phase = P_IDLE;
                m_valid = 1'b0;
            end else if (m_phase == P_IDLE) begin
                if (l_tick) m_phase = P_GEN;
            end else if (m_phase == P_GEN) begin
                l_raw   = int'(l_cur % 1024);
                m_x     = (l_raw < c_XMAX) ? l_raw : l_raw - c_XMAX;
                m_speed = int'((l_cur / 1024) % 8);
                if (m_speed == 0) m_speed = 1;
                m_size  = int'((l_cur / 8192) % 4);
                m_valid = 1'b1;
                m_phase = P_OFFER;
            end else begin
                if (spawn_ready) begin
                    m_valid = 1'b0;
                    m_phase = P_IDLE;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("valid",      32'(spawn_valid),      32'(m_valid));
            check("x",          32'(spawn_x),          32'(m_x));
            check("speed",      32'(spawn_speed),      32'(m_speed));
            check("size",       32'(spawn_size),       32'(m_size));
            check("drop_count", 32'(drop_count),       32'(m_drop));
            check("lfsr",       dut.r_lfsr,            m_lfsr);
            check("frame_cnt",  32'(dut.r_frame_cnt),  32'(m_frame));
        end
    end

    // Two frame ticks (second is the spawn tick, with frame counter at 0 on
    // entry); the seed write lands on the spawn tick so the GEN cycle sees it.
    // Returns at the first negedge in OFFER.
    task automatic offer_with(input logic [31:0] s);
        frame_tick = 1'b1;
        @(negedge clk);
        seed = s;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic handshake();
        spawn_ready = 1'b1;
        @(negedge clk);
        spawn_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        seed        = 32'h0;
        enable      = 1'b0;
        frame_tick  = 1'b0;
        spawn_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", 32'(spawn_valid), 32'h0);
        check("rst_x",     32'(spawn_x),     32'h0);
        check("rst_speed", 32'(spawn_speed), 32'h0);
        check("rst_size",  32'(spawn_size),  32'h0);
        check("rst_drop",  32'(drop_count),  32'h0);
        check("rst_lfsr",  dut.r_lfsr,       32'h1);
        reset = 1'b0;

        // Seed held at 0: 1, 3, 6
        @(negedge clk);
        check("lfsr_seq_3", dut.r_lfsr, 32'h3);
        @(negedge clk);
        check("lfsr_seq_6", dut.r_lfsr, 32'h6);

        // All-ones low field: 1023 folds to 383, speed 7, size 3
        enable     = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        seed = 32'h0000_7FFF;
        @(negedge clk);
        frame_tick = 1'b0;
        check("gen_valid_low", 32'(spawn_valid), 32'h0);
        check("gen_lfsr",      dut.r_lfsr,       32'h0000_7FFF);
        @(negedge clk);
        check("offer_valid", 32'(spawn_valid), 32'h1);
        check("offer_x",     32'(spawn_x),     32'd383);
        check("offer_speed", 32'(spawn_speed), 32'd7);
        check("offer_size",  32'(spawn_size),  32'd3);

        // Backpressure across three spawn ticks
        for (int i = 0; i < 6; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        check("bp_drop",  32'(drop_count),  32'd3);
        check("bp_valid", 32'(spawn_valid), 32'h1);
        check("bp_x",     32'(spawn_x),     32'd383);
        check("bp_speed", 32'(spawn_speed), 32'd7);
        handshake();
        check("hs_valid", 32'(spawn_valid), 32'h0);

        // x exactly at X_MAX folds to 0; zero speed becomes 1
        offer_with(32'h0000_0280);
        check("xmax_x",     32'(spawn_x),     32'd0);
        check("xmax_speed", 32'(spawn_speed), 32'd1);
        handshake();
        // x just under X_MAX passes through
        offer_with(32'h0000_027F);
        check("x639_x",     32'(spawn_x),     32'd639);
        check("x639_speed", 32'(spawn_speed), 32'd1);
        handshake();

        // Seed changed to 0 mid-run, then rewritten unchanged
        seed = 32'h0;
        @(negedge clk);
        check("seed0_load", dut.r_lfsr, 32'h1);
        seed = 32'h0;
        @(negedge clk);
        check("seed0_norel", dut.r_lfsr, 32'h3);
        seed = 32'h1234_5678;
        @(negedge clk);
        check("seed_load", dut.r_lfsr, 32'h1234_5678);
        seed = 32'h1234_5678;
        @(negedge clk);
        check("seed_norel", dut.r_lfsr, 32'h2468_ACF1);

        // Enable dropped during OFFER
        offer_with(32'h0000_1234);
        check("e_valid", 32'(spawn_valid), 32'h1);
        check("e_x",     32'(spawn_x),     32'd564);
        check("e_speed", 32'(spawn_speed), 32'd4);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("e_frame1", 32'(dut.r_frame_cnt), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(spawn_valid),      32'h0);
        check("flush_frame", 32'(dut.r_frame_cnt),  32'd0);
        enable = 1'b1;

        // Reset during OFFER
        offer_with(32'h0000_4321);
        check("r_valid_pre", 32'(spawn_valid), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("r_valid", 32'(spawn_valid), 32'h0);
        check("r_x",     32'(spawn_x),     32'h0);
        check("r_speed", 32'(spawn_speed), 32'h0);
        check("r_size",  32'(spawn_size),  32'h0);
        check("r_drop",  32'(drop_count),  32'h0);
        reset = 1'b0;
        // Nonzero seed loads on the first cycle after reset
        @(negedge clk);
        check("post_rst_seed", dut.r_lfsr, 32'h0000_4321);

        // Drop counter saturation
        frame_tick = 1'b1;
        repeat (600) @(negedge clk);
        frame_tick = 1'b0;
        check("sat_drop",  32'(drop_count),  32'd255);
        check("sat_valid", 32'(spawn_valid), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            enable      = ($urandom_range(0, 19) != 0);
            frame_tick  = ($urandom_range(0, 2) == 0);
            spawn_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0)
                seed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset       = 1'b0;
        frame_tick  = 1'b0;
        spawn_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/meteor_spawn_rng.md
METEOR_SPAWN_RNG -- requirements
Module: meteor_spawn_rng

Interface
REQ-001 The block SHALL have parameter SPAWN_PERIOD, default 30, meaning the number of frame_tick pulses between spawn attempts (legal range 1..255).
REQ-002 The block SHALL have parameter X_MAX, default 640, meaning the exclusive upper bound of spawn_x (legal range 512..1023).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port seed, input, 32 bits: seed value driven by the CPU-written random_number PIO output port.
REQ-006 The block SHALL have port enable, input, 1 bit: spawning enabled while high.
REQ-007 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-008 The block SHALL have port spawn_ready, input, 1 bit: consumer accepts the offered spawn.
REQ-009 The block SHALL have port spawn_valid, output, 1 bit: a spawn descriptor is offered.
REQ-010 The block SHALL have port spawn_x, output, 10 bits: horizontal spawn position, range 0..X_MAX-1.
REQ-011 The block SHALL have port spawn_speed, output, 3 bits: fall speed, range 1..7.
REQ-012 The block SHALL have port spawn_size, output, 2 bits: meteor size class.
REQ-013 The block SHALL have port drop_count, output, 8 bits: saturating count of spawns dropped due to backpressure.

Function
REQ-014 The LFSR SHALL be a 32-bit register that advances every cycle as next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}, except in a seed-load cycle.
REQ-015 The block SHALL keep a register seed_q; when seed != seed_q, it SHALL load the LFSR with seed and set seed_q = seed on the next edge, and a seed of 0 SHALL load 32'h00000001 instead.
REQ-016 A seed load SHALL take priority over LFSR advance in the same cycle.
REQ-017 A frame counter (8 bits) SHALL increment on each frame_tick while enable is high, and SHALL wrap to 0 on the tick at which it equals SPAWN_PERIOD-1; that tick is the spawn tick.
REQ-018 The FSM SHALL have states IDLE, GEN, and OFFER.
REQ-019 In IDLE, the FSM SHALL move to GEN on the cycle after a spawn tick.
REQ-020 In GEN (one cycle), the block SHALL sample the current LFSR value L (pre-update) into the output registers and move to OFFER.
REQ-021 spawn_x SHALL be L[9:0] if L[9:0] < X_MAX, else L[9:0] - X_MAX (single subtraction).
REQ-022 spawn_speed SHALL be L[12:10], with 0 replaced by 1.
REQ-023 spawn_size SHALL be L[14:13].
REQ-024 In OFFER, spawn_valid SHALL be 1, and spawn_x, spawn_speed and spawn_size SHALL be held stable until the cycle in which spawn_valid && spawn_ready, after which the FSM SHALL return to IDLE with spawn_valid 0 on the next cycle.
REQ-025 spawn_valid SHALL be 0 in IDLE and GEN, and total latency from spawn tick to spawn_valid SHALL be 2 cycles.
REQ-026 A spawn tick occurring while in GEN or OFFER SHALL NOT start a new generation and SHALL increment drop_count, saturating at 255.
REQ-027 A spawn tick in the same cycle as the OFFER handshake SHALL also count as dropped.
REQ-028 When enable is low, the frame counter SHALL be cleared to 0, and the FSM SHALL go to IDLE on the next edge, withdrawing spawn_valid (flush; the only permitted valid drop without ready).
REQ-029 The LFSR and seed detection SHALL keep running regardless of enable.
REQ-030 spawn_ready while spawn_valid is 0 SHALL have no effect.

Reset
REQ-031 While reset is high at a clk edge, the block SHALL set lfsr = 32'h00000001, seed_q = 0, frame counter = 0, and state = IDLE.
REQ-032 The same reset SHALL set spawn_valid, spawn_x, spawn_speed, spawn_size and drop_count to 0.
REQ-033 Reset SHALL take priority over all other inputs, including mid-OFFER, where the offer is discarded without a handshake.
REQ-034 On the first cycle after reset, a nonzero seed SHALL trigger a seed load per REQ-015.

Verification
REQ-035 The bench SHALL cover: seed held at 0 after reset -> lfsr sequence 0x00000001, 0x00000003, 0x00000006 on successive cycles.
REQ-036 The bench SHALL cover: SPAWN_PERIOD=2 with a GEN-cycle L[14:0] = 15'h7FFF -> spawn_x=383, spawn_speed=7, spawn_size=3, with spawn_valid asserted 2 cycles after the second frame_tick.
REQ-037 The bench SHALL cover: GEN-cycle L[12:0] = 13'h0280 -> spawn_x=0 and spawn_speed=1; with L[9:0] = 639 -> spawn_x=639.
REQ-038 The bench SHALL cover: spawn_ready held low across 3 further spawn ticks -> outputs stable, drop_count=3; then ready high for 1 cycle -> spawn_valid 0 on the next cycle.
REQ-039 The bench SHALL cover: seed changed to 0 mid-run -> lfsr = 0x00000001 one cycle later, and seed rewritten to the same value -> no reload.
REQ-040 The bench SHALL cover: enable dropped during OFFER -> spawn_valid 0 on the next cycle and frame counter 0; reset asserted during OFFER -> all outputs 0 on the next cycle.
